// File: rtl/gshare_index.sv
`default_nettype none
// ============================================================================
// Module   : gshare_index
// Brief    : Global-history (gshare) index generator for the PHT lookup path.
//            Keeps a global history register, hashes it with the FETCH PC to
//            form the PHT index, reports DECODE-stage mispredicts and keeps
//            saturating branch / mispredict statistics.
//            Optional feature macro: GSHARE_SPEC_HISTORY_EN
//              defined   -> speculative history shift at lookup with
//                           checkpoint repair on mispredict
//              undefined -> history shifts only with resolved outcomes
// Revision : 1.0 - initial release
// ============================================================================
module gshare_index #(
    parameter int IWIDTH = 6,
    parameter int HWIDTH = 4,
    parameter int CWIDTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              do_lookup,
    input  logic [31:0]       pc,
    input  logic              pred,
    input  logic              do_update,
    input  logic              last_taken,
    output logic [IWIDTH-1:0] index,
    output logic              mispredict,
    output logic [CWIDTH-1:0] branch_cnt,
    output logic [CWIDTH-1:0] mispredict_cnt
);

    // Saturation ceiling and increment step for the statistics counters.
    localparam logic [CWIDTH-1:0] c_cnt_max = {CWIDTH{1'b1}};
    localparam logic [CWIDTH-1:0] c_cnt_one = CWIDTH'(1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [HWIDTH-1:0] ghr_q;
    logic [HWIDTH-1:0] ghr_d;
    logic              last_pred_q;
    logic              last_pred_d;
    logic              pending_q;
    logic              pending_d;
    logic [CWIDTH-1:0] branch_cnt_q;
    logic [CWIDTH-1:0] branch_cnt_d;
    logic [CWIDTH-1:0] mispredict_cnt_q;
    logic [CWIDTH-1:0] mispredict_cnt_d;

`ifdef GSHARE_SPEC_HISTORY_EN
    // History as it stood before the most recent speculative shift; the
    // repair point when the branch resolves against its prediction.
    logic [HWIDTH-1:0] ckpt_q;
    logic [HWIDTH-1:0] ckpt_d;
    // History after any protocol-slip update this edge; the base that a
    // concurrent lookup checkpoints and shifts.
    logic [HWIDTH-1:0] w_hist_base;
`endif

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic              w_mispredict;
    logic              w_resolve_pending;
    logic              w_resolve_slip;
    logic [CWIDTH-1:0] w_branch_cnt_inc;
    logic [CWIDTH-1:0] w_mispredict_cnt_inc;

    // Only bits [IWIDTH+1:2] of the PC participate in the hash; the rest are
    // folded into a sink so the unused bits are explicit.
    logic              w_unused_pc;

    assign w_unused_pc = ^{pc[31:IWIDTH+2], pc[1:0]};

    // A mispredict needs an outstanding lookup whose recorded prediction
    // disagrees with the resolved outcome of the DECODE branch.
    assign w_mispredict = en & do_update & pending_q & (last_taken != last_pred_q);

    // DECODE branch resolved against an outstanding lookup (correct or not).
    assign w_resolve_pending = en & do_update & pending_q;

    // DECODE branch with no outstanding lookup: history absorbs the outcome.
    assign w_resolve_slip = en & do_update & ~pending_q;

    // Saturating +1 values; counters stop at all-ones instead of wrapping.
    assign w_branch_cnt_inc     = (branch_cnt_q == c_cnt_max) ?
                                  branch_cnt_q : (branch_cnt_q + c_cnt_one);
    assign w_mispredict_cnt_inc = (mispredict_cnt_q == c_cnt_max) ?
                                  mispredict_cnt_q : (mispredict_cnt_q + c_cnt_one);

    // ------------------------------------------------------------------------
    // PHT index: PC word address hashed with the current history. The PHT
    // prediction feeds back only through the registered history, so there is
    // no combinational loop through pred.
    // ------------------------------------------------------------------------
    generate
        if (IWIDTH > HWIDTH) begin : g_idx_pad
            assign index = pc[IWIDTH+1:2] ^ {{(IWIDTH-HWIDTH){1'b0}}, ghr_q};
        end else begin : g_idx_full
            assign index = pc[IWIDTH+1:2] ^ ghr_q;
        end
    endgenerate

    assign mispredict     = w_mispredict;
    assign branch_cnt     = branch_cnt_q;
    assign mispredict_cnt = mispredict_cnt_q;

    // Track the outstanding lookup: a mispredict squashes the concurrent
    // fetch, otherwise a lookup opens a new pending slot and no lookup closes it.
    always_comb begin
        pending_d   = pending_q;
        last_pred_d = last_pred_q;
        if (en) begin
            if (w_mispredict) begin
                pending_d = 1'b0;
            end else if (do_lookup) begin
                pending_d   = 1'b1;
                last_pred_d = pred;
            end else begin
                pending_d = 1'b0;
            end
        end
    end

    // Statistics: every resolution against a pending lookup counts as a
    // branch; mispredicts are counted in addition. Slip updates are not counted.
    always_comb begin
        branch_cnt_d     = branch_cnt_q;
        mispredict_cnt_d = mispredict_cnt_q;
        if (w_mispredict) begin
            branch_cnt_d     = w_branch_cnt_inc;
            mispredict_cnt_d = w_mispredict_cnt_inc;
        end else if (w_resolve_pending) begin
            branch_cnt_d = w_branch_cnt_inc;
        end
    end

`ifdef GSHARE_SPEC_HISTORY_EN
    // Speculative history: shift in the prediction at lookup, rebuild from
    // the checkpoint plus the real outcome on mispredict. A slip update and a
    // lookup on the same edge compose: the slip result is the lookup's base.
    always_comb begin
        w_hist_base = ghr_q;
        if (w_resolve_slip) begin
            w_hist_base = {ghr_q[HWIDTH-2:0], last_taken};
        end

        ghr_d  = ghr_q;
        ckpt_d = ckpt_q;
        if (w_mispredict) begin
            ghr_d = {ckpt_q[HWIDTH-2:0], last_taken};
        end else if (en) begin
            ghr_d = w_hist_base;
            if (do_lookup) begin
                ckpt_d = w_hist_base;
                ghr_d  = {w_hist_base[HWIDTH-2:0], pred};
            end
        end
    end

    // Checkpoint register, present only with speculative history.
    always_ff @(posedge clk) begin
        if (reset) begin
            ckpt_q <= '0;
        end else begin
            ckpt_q <= ckpt_d;
        end
    end
`else
    // Non-speculative history: only resolved outcomes enter the history,
    // whether or not a lookup was pending; lookups never shift it.
    always_comb begin
        ghr_d = ghr_q;
        if (en && do_update) begin
            ghr_d = {ghr_q[HWIDTH-2:0], last_taken};
        end
    end
`endif

    // Architectural state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            ghr_q            <= '0;
            last_pred_q      <= 1'b0;
            pending_q        <= 1'b0;
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            ghr_q            <= ghr_d;
            last_pred_q      <= last_pred_d;
            pending_q        <= pending_d;
            branch_cnt_q     <= branch_cnt_d;
            mispredict_cnt_q <= mispredict_cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_gshare_index.sv
`default_nettype none
// ============================================================================
// Module   : tb_gshare_index
// Brief    : Directed self-checking bench for gshare_index. A behavioural
//            model of the history/pending/counter rules runs alongside the
//            DUT and is compared every cycle; hand-computed literals pin the
//            model along the directed sequence. Builds for either setting of
//            GSHARE_SPEC_HISTORY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gshare_index;

    localparam int IWIDTH = 6;
    localparam int HWIDTH = 4;
    localparam int CWIDTH = 4;
    localparam int HMASK  = (1 << HWIDTH) - 1;
    localparam int IMASK  = (1 << IWIDTH) - 1;
    localparam int CMAX   = (1 << CWIDTH) - 1;
`ifdef GSHARE_SPEC_HISTORY_EN
    localparam bit SPEC   = 1'b1;
`else
    localparam bit SPEC   = 1'b0;
`endif

    logic              clk;
    logic              reset;
    logic              en;
    logic              do_lookup;
    logic [31:0]       pc;
    logic              pred;
    logic              do_update;
    logic              last_taken;
    logic [IWIDTH-1:0] index;
    logic              mispredict;
    logic [CWIDTH-1:0] branch_cnt;
    logic [CWIDTH-1:0] mispredict_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state.
    int m_ghr       = 0;
    int m_ckpt      = 0;
    int m_last_pred = 0;
    int m_pending   = 0;
    int m_bcnt      = 0;
    int m_mcnt      = 0;

    gshare_index #(
        .IWIDTH(IWIDTH),
        .HWIDTH(HWIDTH),
        .CWIDTH(CWIDTH)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .en            (en),
        .do_lookup     (do_lookup),
        .pc            (pc),
        .pred          (pred),
        .do_update     (do_update),
        .last_taken    (last_taken),
        .index         (index),
        .mispredict    (mispredict),
        .branch_cnt    (branch_cnt),
        .mispredict_cnt(mispredict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int push_bit(input int h, input int b);
        return ((h << 1) | (b & 1)) & HMASK;
    endfunction

    function automatic int sat_inc(input int v);
        return (v < CMAX) ? v + 1 : CMAX;
    endfunction

    // Model update at each rising edge from the inputs held over that edge.
    always @(posedge clk) begin
        int mp;
        if (reset) begin
            m_ghr = 0; m_ckpt = 0; m_last_pred = 0; m_pending = 0;
            m_bcnt = 0; m_mcnt = 0;
        end else if (en) begin
            mp = (do_update && m_pending != 0 && int'(last_taken) != m_last_pred) ? 1 : 0;
            if (SPEC) begin
                if (mp != 0) begin
                    m_ghr = push_bit(m_ckpt, int'(last_taken));
                end else begin
                    if (do_update && m_pending == 0) m_ghr = push_bit(m_ghr, int'(last_taken));
                    if (do_lookup) begin
                        m_ckpt = m_ghr;
                        m_ghr  = push_bit(m_ghr, int'(pred));
                    end
                end
            end else begin
                if (do_update) m_ghr = push_bit(m_ghr, int'(last_taken));
            end
            if (mp != 0) begin
                m_bcnt = sat_inc(m_bcnt);
                m_mcnt = sat_inc(m_mcnt);
                m_pending = 0;
            end else begin
                if (do_update && m_pending != 0) m_bcnt = sat_inc(m_bcnt);
                if (do_lookup) begin
                    m_pending   = 1;
                    m_last_pred = int'(pred);
                end else begin
                    m_pending = 0;
                end
            end
        end
    end

    // Compare DUT outputs against the model at every falling edge out of reset.
    always @(negedge clk) begin
        int exp_idx;
        int exp_mp;
        if (reset === 1'b0) begin
            exp_idx = (int'(pc >> 2) & IMASK) ^ m_ghr;
            exp_mp  = (en && do_update && m_pending != 0 &&
                       int'(last_taken) != m_last_pred) ? 1 : 0;
            chk("model_index",          int'(index),          exp_idx);
            chk("model_mispredict",     int'(mispredict),     exp_mp);
            chk("model_branch_cnt",     int'(branch_cnt),     m_bcnt);
            chk("model_mispredict_cnt", int'(mispredict_cnt), m_mcnt);
        end
    end

    // One cycle: drive inputs just after the rising edge, return at the
    // falling edge so literal checks sample settled outputs.
    task automatic cyc(input logic r, input logic e, input logic lk, input logic [31:0] p,
                       input logic pr, input logic up, input logic lt);
        @(posedge clk);
        #1;
        reset = r; en = e; do_lookup = lk; pc = p;
        pred = pr; do_update = up; last_taken = lt;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; do_lookup = 1'b0; pc = 32'h0;
        pred = 1'b0; do_update = 1'b0; last_taken = 1'b0;

        cyc(1, 0, 0, 32'h0, 0, 0, 0);
        cyc(1, 0, 0, 32'h0, 0, 0, 0);

        // Reset state
        cyc(0, 1, 0, 32'hA4, 0, 0, 0);
        chk("rst_index", int'(index), 'h29);
        chk("rst_mispredict", int'(mispredict), 0);
        chk("rst_branch_cnt", int'(branch_cnt), 0);
        chk("rst_mispredict_cnt", int'(mispredict_cnt), 0);

        // Lookup pred=1, then correct resolution
        cyc(0, 1, 1, 32'hA4, 1, 0, 0);
        chk("lookup_index", int'(index), 'h29);
        cyc(0, 1, 0, 32'hA4, 0, 1, 1);
        chk("spec_shift_index", int'(index), SPEC ? 'h28 : 'h29);
        chk("correct_mispredict", int'(mispredict), 0);
        cyc(0, 1, 0, 32'h0, 0, 0, 0);
        chk("after_correct_ghr", int'(index), 'h01);
        chk("after_correct_bcnt", int'(branch_cnt), 1);

        // Lookup pred=1, then mispredict with a concurrent lookup
        cyc(0, 1, 1, 32'h0, 1, 0, 0);
        chk("lookup2_index", int'(index), 'h01);
        cyc(0, 1, 1, 32'h0, 1, 1, 0);
        chk("mp_index", int'(index), SPEC ? 'h03 : 'h01);
        chk("mp_flag", int'(mispredict), 1);
        // Dropped lookup: an opposing outcome must not flag a mispredict
        cyc(0, 1, 0, 32'h0, 0, 1, 0);
        chk("repair_index", int'(index), 'h02);
        chk("dropped_lookup", int'(mispredict), 0);
        chk("mp_bcnt", int'(branch_cnt), 2);
        chk("mp_mcnt", int'(mispredict_cnt), 1);
        cyc(0, 1, 0, 32'h0, 0, 0, 0);
        chk("slip_index", int'(index), 'h04);

        // en=0 hold with a lookup pending
        cyc(0, 1, 1, 32'h0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1, 32'h0, 1, 1, 1);
            chk("hold_index", int'(index), SPEC ? 'h08 : 'h04);
            chk("hold_mispredict", int'(mispredict), 0);
            chk("hold_bcnt", int'(branch_cnt), 2);
        end
        cyc(0, 1, 0, 32'h0, 0, 1, 1);
        chk("held_pending_mp", int'(mispredict), 1);
        cyc(0, 1, 0, 32'h0, 0, 0, 0);
        chk("held_repair_index", int'(index), 'h09);
        chk("held_bcnt", int'(branch_cnt), 3);
        chk("held_mcnt", int'(mispredict_cnt), 2);

        // 20 lookup/mispredict pairs: counters saturate at 15
        for (int i = 0; i < 20; i++) begin
            cyc(0, 1, 1, 32'h0, 1, 0, 0);
            cyc(0, 1, 0, 32'h0, 0, 1, 0);
            chk("pair_mispredict", int'(mispredict), 1);
        end
        cyc(0, 1, 0, 32'h0, 0, 0, 0);
        chk("sat_bcnt", int'(branch_cnt), 15);
        chk("sat_mcnt", int'(mispredict_cnt), 15);
        chk("sat_index", int'(index), 'h00);

        // Slip update composed with a lookup
        cyc(0, 1, 1, 32'h0, 1, 1, 1);
        cyc(0, 1, 0, 32'h0, 0, 1, 1);
        chk("compose_index", int'(index), SPEC ? 'h03 : 'h01);
        chk("compose_mispredict", int'(mispredict), 0);
        chk("compose_bcnt_sat", int'(branch_cnt), 15);

        // Mid-operation reset loses the pending lookup
        cyc(0, 1, 1, 32'h0, 0, 0, 0);
        cyc(1, 1, 0, 32'h0, 0, 0, 0);
        cyc(0, 1, 0, 32'h0, 0, 1, 1);
        chk("post_rst_mispredict", int'(mispredict), 0);
        chk("post_rst_index", int'(index), 'h00);
        chk("post_rst_bcnt", int'(branch_cnt), 0);
        chk("post_rst_mcnt", int'(mispredict_cnt), 0);
        cyc(0, 1, 0, 32'hFFFF_FFFC, 0, 0, 0);
        chk("post_rst_slip_index", int'(index), 'h3E);
        chk("post_rst_slip_bcnt", int'(branch_cnt), 0);

        cyc(0, 0, 0, 32'h0, 0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
